if_fetch: RTL and testbench

- Instruction-fetch stage: owns the PC and issues fetch requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents registered {if_valid, if_pc, if_inst} to the IF/ID pipeline register.
- Handles hazard-unit stalls through a 1-entry hold buffer.
- Handles branch redirects from EX by flushing its output and discarding in-flight responses.
- Fetch is single-outstanding.

---
 rtl/if_fetch_pkg.sv | 14 +
 rtl/if_hold_buf.sv | 40 ++++
 rtl/if_fetch.sv | 143 ++++++++++++++
 tb/tb_if_fetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants and FSM state encoding for the fetch stage
package if_fetch_pkg;

    localparam int unsigned PC_WIDTH_DEF = 32;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_REQ   = 2'd0,
        IF_WAIT  = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DRAIN = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - single-entry {pc, inst} buffer for responses that arrive during a stall
module if_hold_buf
    import if_fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                clear_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [31:0]         inst_i,
    output logic                valid_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [31:0]         inst_o
);

    logic                valid_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [31:0]         inst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, single-outstanding imem requests, IF/ID output register
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [31:0]         NOP_INST = NOP_INST_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req_valid,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    output logic                if_valid,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [31:0]         if_inst
);

    if_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                out_valid_q, out_valid_d;
    logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [31:0]         out_inst_q, out_inst_d;

    logic                hold_load, hold_clear, hold_valid;
    logic [PC_WIDTH-1:0] hold_pc;
    logic [31:0]         hold_inst;

    logic                req_fire;
    logic                deliver;
    logic [PC_WIDTH-1:0] deliver_pc;
    logic [31:0]         deliver_inst;

    if_hold_buf #(.PC_WIDTH(PC_WIDTH)) u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .pc_i    (pc_q),
        .inst_i  (imem_rsp_data),
        .valid_o (hold_valid),
        .pc_o    (hold_pc),
        .inst_o  (hold_inst)
    );

    assign req_fire = (state_q == IF_REQ) && imem_req_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        deliver      = 1'b0;
        deliver_pc   = pc_q;
        deliver_inst = imem_rsp_data;

        case (state_q)
            IF_REQ: begin
                if (req_fire) state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if (imem_rsp_valid) begin
                    if (!stall) begin
                        deliver = 1'b1;
                        pc_d    = pc_q + PC_WIDTH'(4);
                        state_d = IF_REQ;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = IF_HOLD;
                    end
                end
            end
            IF_HOLD: begin
                if (!stall && hold_valid) begin
                    deliver      = 1'b1;
                    deliver_pc   = hold_pc;
                    deliver_inst = hold_inst;
                    hold_clear   = 1'b1;
                    pc_d         = pc_q + PC_WIDTH'(4);
                    state_d      = IF_REQ;
                end
            end
            IF_DRAIN: begin
                if (imem_rsp_valid) state_d = IF_REQ;
            end
            default: state_d = IF_REQ;
        endcase

        if (!stall) begin
            out_valid_d = deliver;
            out_inst_d  = deliver ? deliver_inst : NOP_INST;
            if (deliver) out_pc_d = deliver_pc;
        end

        // A redirect wins over everything: flush the output and hold buffer, and
        // only drain when a response is still owed by the memory.
        if (redirect_valid) begin
            pc_d        = redirect_pc & ~PC_WIDTH'(3);
            hold_load   = 1'b0;
            hold_clear  = 1'b1;
            out_valid_d = 1'b0;
            out_inst_d  = NOP_INST;
            out_pc_d    = out_pc_q;
            case (state_q)
                IF_REQ:   state_d = req_fire       ? IF_DRAIN : IF_REQ;
                IF_WAIT:  state_d = imem_rsp_valid ? IF_REQ   : IF_DRAIN;
                IF_DRAIN: state_d = imem_rsp_valid ? IF_REQ   : IF_DRAIN;
                default:  state_d = IF_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IF_REQ;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= NOP_INST;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
        end
    end

    assign imem_req_valid = (state_q == IF_REQ) && rst_n;
    assign imem_req_addr  = {pc_q[PC_WIDTH-1:2], 2'b00};
    assign if_valid       = out_valid_q;
    assign if_pc          = out_pc_q;
    assign if_inst        = out_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed and randomized bench for if_fetch with an in-order fetch-stream model
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int          vectors;
    int          miscompares;
    int          consumed;
    int          lat_cfg;
    int          mem_lat;
    logic        mem_busy;
    logic [31:0] mem_addr;
    logic [31:0] exp_pc;

    if_fetch #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0),
        .NOP_INST (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_00A0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after negedge, model memory and the
    // program-order instruction stream across the posedge.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic        rsp, hs;
        logic        pre_rv, pre_iv;
        logic [31:0] pre_addr, pre_pc, pre_inst;
        rsp            = mem_busy && (mem_lat == 0);
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
        #1;
        pre_rv   = imem_req_valid;
        pre_addr = imem_req_addr;
        pre_iv   = if_valid;
        pre_pc   = if_pc;
        pre_inst = if_inst;
        @(posedge clk);
        hs = pre_rv && rdy;
        if (hs) begin
            chk("single_outstanding", {31'b0, mem_busy && !rsp}, 32'd0);
            chk("req_addr_align", {30'b0, pre_addr[1:0]}, 32'd0);
        end
        if (rd) begin
            exp_pc = rpc & ~32'd3;
        end else if (!st && pre_iv) begin
            chk("stream_pc", pre_pc, exp_pc);
            chk("stream_inst", pre_inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (rsp) mem_busy = 1'b0;
        else if (mem_busy) mem_lat--;
        if (hs) begin
            mem_busy = 1'b1;
            mem_addr = pre_addr;
            mem_lat  = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 2));
        end
        #1;
        if (rd) chk("redirect_bubble", {31'b0, if_valid}, 32'd0);
        if (st && !rd) begin
            chk("stall_frozen_valid", {31'b0, if_valid}, {31'b0, pre_iv});
            chk("stall_frozen_pc", if_pc, pre_pc);
            chk("stall_frozen_inst", if_inst, pre_inst);
        end
        if (!if_valid) chk("bubble_nop", if_inst, NOP);
        @(negedge clk);
    endtask

    initial begin
        vectors = 0; miscompares = 0; consumed = 0;
        lat_cfg = 0; mem_lat = 0; mem_busy = 1'b0; mem_addr = '0; exp_pc = '0;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, NOP);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);

        // Zero-wait memory: request, response, request, ...
        tick(0, 0, 0, 1);
        chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick(0, 0, 0, 1);
        chk("deliver0_valid", {31'b0, if_valid}, 32'd1);
        chk("deliver0_pc", if_pc, 32'h0);
        chk("deliver0_inst", if_inst, 32'hA0);
        chk("req4_addr", imem_req_addr, 32'h4);
        tick(0, 0, 0, 1);
        chk("bubble_after0", {31'b0, if_valid}, 32'd0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("deliver8_pc", if_pc, 32'h8);
        chk("deliver8_inst", if_inst, 32'hA8);

        // Memory not ready: request must stay up with a stable address.
        for (int i = 0; i < 3; i++) begin
            chk("notready_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("notready_addr", imem_req_addr, 32'hC);
            tick(0, 0, 0, 0);
        end
        tick(0, 0, 0, 1);

        // Response lands during a stall and sits in the hold buffer.
        tick(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
            tick(1, 0, 0, 1);
        end
        tick(0, 0, 0, 1);
        chk("unhold_valid", {31'b0, if_valid}, 32'd1);
        chk("unhold_pc", if_pc, 32'hC);
        chk("unhold_inst", if_inst, mem_word(32'hC));
        chk("unhold_req_addr", imem_req_addr, 32'h10);

        // Redirect while a response is still owed: drain it, then refetch.
        lat_cfg = 1;
        tick(0, 0, 0, 1);
        tick(0, 1, 32'h103, 1);
        chk("drain_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick(0, 0, 0, 1);
        chk("after_drain_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("after_drain_addr", imem_req_addr, 32'h100);
        chk("after_drain_if_valid", {31'b0, if_valid}, 32'd0);

        // Redirect coincident with the response: no drain cycle.
        lat_cfg = 0;
        tick(0, 0, 0, 1);
        tick(0, 1, 32'h200, 1);
        chk("redir_rsp_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("redir_rsp_req_addr", imem_req_addr, 32'h200);

        // Redirect while holding under stall.
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 1);
        tick(1, 1, 32'h300, 1);
        chk("redir_hold_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("redir_hold_req_addr", imem_req_addr, 32'h300);
        chk("redir_hold_if_valid", {31'b0, if_valid}, 32'd0);

        // PC wrap at the top of the address space.
        tick(0, 1, 32'hFFFF_FFFF, 0);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("wrap_deliver_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_next_addr", imem_req_addr, 32'h0);

        // Asynchronous reset in WAIT with a valid instruction presented.
        lat_cfg = 1;
        tick(1, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_if_valid", {31'b0, if_valid}, 32'd0);
        chk("async_if_pc", if_pc, 32'd0);
        chk("async_if_inst", if_inst, NOP);
        chk("async_req_valid", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_busy = 1'b0;
        exp_pc = '0;

        // Random traffic against the program-order stream model.
        lat_cfg = -1;
        consumed = 0;
        for (int i = 0; i < 600; i++) begin
            tick(($urandom % 3) == 0, ($urandom % 15) == 0, $urandom, ($urandom % 4) != 0);
        end
        chk("random_progress", {31'b0, consumed > 40}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
